// File: rtl/issue_scheduler.sv
// Dual-lane in-order issue stage: decodes the two oldest buffer entries, checks them
// against a register scoreboard and issues zero, one or two instructions per cycle.
module issue_scheduler (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        flush,
    input  logic [31:0] entry0_instruction,
    input  logic [31:0] entry1_instruction,
    input  logic [31:0] entry0_address,
    input  logic [31:0] entry1_address,
    input  logic [3:0]  entry_count,
    input  logic        lane0_ready,
    input  logic        lane1_ready,
    input  logic [1:0]  wb_valid,
    input  logic [4:0]  wb_rd0,
    input  logic [4:0]  wb_rd1,
    output logic        pop0,
    output logic        pop1,
    output logic        lane0_valid,
    output logic        lane1_valid,
    output logic [31:0] lane0_instruction,
    output logic [31:0] lane0_address,
    output logic [31:0] lane1_instruction,
    output logic [31:0] lane1_address,
    output logic [15:0] stall_cycles
);

    localparam logic [6:0] OPC_OP       = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
    localparam logic [6:0] OPC_LOAD     = 7'b0000011;
    localparam logic [6:0] OPC_STORE    = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
    localparam logic [6:0] OPC_LUI      = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
    localparam logic [6:0] OPC_JAL      = 7'b1101111;
    localparam logic [6:0] OPC_JALR     = 7'b1100111;
    localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;
    localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;

    function automatic logic uses_rs1(input logic [31:0] inst);
        return !(inst[6:0] == OPC_LUI || inst[6:0] == OPC_AUIPC || inst[6:0] == OPC_JAL);
    endfunction

    function automatic logic uses_rs2(input logic [31:0] inst);
        return inst[6:0] == OPC_OP || inst[6:0] == OPC_STORE || inst[6:0] == OPC_BRANCH;
    endfunction

    function automatic logic writes_rd(input logic [31:0] inst);
        logic wr_op;
        wr_op = inst[6:0] == OPC_OP  || inst[6:0] == OPC_OP_IMM || inst[6:0] == OPC_LOAD ||
                inst[6:0] == OPC_LUI || inst[6:0] == OPC_AUIPC  || inst[6:0] == OPC_JAL  ||
                inst[6:0] == OPC_JALR;
        return wr_op && (inst[11:7] != 5'd0);
    endfunction

    // Lane 1 is a plain ALU lane: control flow, memory and system ops stay on lane 0.
    function automatic logic lane1_capable(input logic [31:0] inst);
        return !(inst[6:0] == OPC_BRANCH || inst[6:0] == OPC_JAL   || inst[6:0] == OPC_JALR ||
                 inst[6:0] == OPC_LOAD   || inst[6:0] == OPC_STORE || inst[6:0] == OPC_SYSTEM ||
                 inst[6:0] == OPC_MISC_MEM);
    endfunction

    function automatic logic sb_hazard(input logic [31:0] inst, input logic [31:0] sb);
        return (uses_rs1(inst)  && sb[inst[19:15]]) ||
               (uses_rs2(inst)  && sb[inst[24:20]]) ||
               (writes_rd(inst) && sb[inst[11:7]]);
    endfunction

    logic [31:0] busy;
    logic [31:0] busy_next;
    logic        issue0;
    logic        issue1;
    logic        pair_dep;
    logic [4:0]  rd0;

    assign rd0 = entry0_instruction[11:7];

    assign pair_dep = writes_rd(entry0_instruction) &&
                      ((uses_rs1(entry1_instruction)  && entry1_instruction[19:15] == rd0) ||
                       (uses_rs2(entry1_instruction)  && entry1_instruction[24:20] == rd0) ||
                       (writes_rd(entry1_instruction) && entry1_instruction[11:7]  == rd0));

    assign issue0 = rst_n && (entry_count != 4'd0) && lane0_ready && !flush &&
                    !sb_hazard(entry0_instruction, busy);

    assign issue1 = issue0 && (entry_count >= 4'd2) && lane1_ready &&
                    lane1_capable(entry1_instruction) &&
                    !sb_hazard(entry1_instruction, busy) && !pair_dep;

    assign pop0 = issue0;
    assign pop1 = issue1;

    // Clears are applied before sets so an issue and a writeback to the same register leave it busy.
    always_comb begin
        busy_next = busy;
        if (wb_valid[0]) busy_next[wb_rd0] = 1'b0;
        if (wb_valid[1]) busy_next[wb_rd1] = 1'b0;
        if (issue0 && writes_rd(entry0_instruction)) busy_next[entry0_instruction[11:7]] = 1'b1;
        if (issue1 && writes_rd(entry1_instruction)) busy_next[entry1_instruction[11:7]] = 1'b1;
        busy_next[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy              <= '0;
            lane0_valid       <= 1'b0;
            lane1_valid       <= 1'b0;
            lane0_instruction <= '0;
            lane0_address     <= '0;
            lane1_instruction <= '0;
            lane1_address     <= '0;
            stall_cycles      <= '0;
        end else if (flush) begin
            busy        <= '0;
            lane0_valid <= 1'b0;
            lane1_valid <= 1'b0;
        end else begin
            busy        <= busy_next;
            lane0_valid <= issue0;
            lane1_valid <= issue1;
            if (issue0) begin
                lane0_instruction <= entry0_instruction;
                lane0_address     <= entry0_address;
            end
            if (issue1) begin
                lane1_instruction <= entry1_instruction;
                lane1_address     <= entry1_address;
            end
            if (entry_count != 4'd0 && !issue0 && stall_cycles != 16'hFFFF)
                stall_cycles <= stall_cycles + 16'd1;
        end
    end

endmodule
